// File: rtl/uart_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx : FIFO-buffered UART transmitter (start, 8 data LSB-first, parity, stop)
// Optional even-parity bit enabled by defining UART_TX_PARITY_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module uart_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             TX_baud_tick,
    input  logic [7:0]       data_in,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             txd,
    output logic             tx_busy,
    output logic [CNT_W-1:0] fifo_count
);

    localparam int               c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] c_DEPTH  = CNT_W'(FIFO_DEPTH);
    localparam logic [2:0]       c_IDLE   = 3'd0;
    localparam logic [2:0]       c_START  = 3'd1;
    localparam logic [2:0]       c_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0]       c_PARITY = 3'd3;
`endif
    localparam logic [2:0]       c_STOP   = 3'd4;

    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [2:0]         r_bit_cnt;
    logic [2:0]         w_bit_nxt;
    logic [7:0]         r_shift;
    logic               r_txd;
    logic               w_txd_nxt;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
`ifdef UART_TX_PARITY_EN
    logic               r_par;
`endif

    assign w_full     = (r_count == c_DEPTH);
    assign w_empty    = (r_count == '0);
    assign w_push     = tx_valid && !w_full;
    assign w_pop      = TX_baud_tick && !w_empty && (r_state == c_IDLE || r_state == c_STOP);
    assign tx_ready   = !w_full;
    assign fifo_count = r_count;
    assign txd        = r_txd;
    assign tx_busy    = (r_state != c_IDLE);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // State register plus the frame datapath that travels with it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= c_IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_txd     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_par     <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_txd     <= w_txd_nxt;
            if (w_pop) begin
                r_shift <= r_mem[r_rd_ptr];
`ifdef UART_TX_PARITY_EN
                r_par   <= ^r_mem[r_rd_ptr];
`endif
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit_cnt;
        if (TX_baud_tick) begin
            case (r_state)
                c_IDLE: begin
                    if (!w_empty) w_state_nxt = c_START;
                end
                c_START: begin
                    w_state_nxt = c_DATA;
                    w_bit_nxt   = 3'd0;
                end
                c_DATA: begin
                    w_bit_nxt = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = c_PARITY;
`else
                        w_state_nxt = c_STOP;
`endif
                    end
                end
`ifdef UART_TX_PARITY_EN
                c_PARITY: w_state_nxt = c_STOP;
`endif
                c_STOP: begin
                    w_state_nxt = w_empty ? c_IDLE : c_START;
                end
                default: w_state_nxt = c_IDLE;
            endcase
        end
    end

    // Line level is decoded from the upcoming state so txd changes on the same edge
    always_comb begin
        w_txd_nxt = 1'b1;
        case (w_state_nxt)
            c_START:  w_txd_nxt = 1'b0;
            c_DATA:   w_txd_nxt = r_shift[w_bit_nxt];
`ifdef UART_TX_PARITY_EN
            c_PARITY: w_txd_nxt = r_par;
`endif
            default:  w_txd_nxt = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// tb_uart_tx : self-checking bench with a queue-based line model, directed vectors and random traffic.
module tb_uart_tx;

    localparam int DEPTH = 4;
    localparam int CW    = 3;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_LEN = 11;
`else
    localparam int FRAME_LEN = 10;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          gen_tick = 1'b0;
    logic          man_tick = 1'b0;
    logic          TX_baud_tick;
    logic [7:0]    data_in = 8'h00;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic          txd;
    logic          tx_busy;
    logic [CW-1:0] fifo_count;

    int checks = 0;
    int errors = 0;
    int mode   = 0;   // 0: no ticks, 1: every 4th clock, 2: random

    assign TX_baud_tick = gen_tick | man_tick;

    uart_tx #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .TX_baud_tick (TX_baud_tick),
        .data_in      (data_in),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .txd          (txd),
        .tx_busy      (tx_busy),
        .fifo_count   (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    initial begin
        int div = 0;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0: gen_tick = 1'b0;
                1: begin div = (div + 1) % 4; gen_tick = (div == 0); end
                default: gen_tick = ($urandom_range(0, 2) == 0);
            endcase
        end
    end

    // Reference model: a byte queue plus the list of line levels still to be sent.
    logic [7:0] mq[$];
    bit         fq[$];

    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_txd", 32'(txd), 32'd1);
            chk("rst_busy", 32'(tx_busy), 32'd0);
            chk("rst_ready", 32'(tx_ready), 32'd1);
            chk("rst_count", 32'(fifo_count), 32'd0);
            mq.delete();
            fq.delete();
        end else begin
            bit full;
            chk("m_txd", 32'(txd), (fq.size() != 0) ? 32'(fq[0]) : 32'd1);
            chk("m_busy", 32'(tx_busy), 32'(fq.size() != 0));
            chk("m_ready", 32'(tx_ready), 32'(mq.size() < DEPTH));
            chk("m_count", 32'(fifo_count), 32'(mq.size()));
            full = (mq.size() == DEPTH);
            if (TX_baud_tick) begin
                if (fq.size() != 0) void'(fq.pop_front());
                if (fq.size() == 0 && mq.size() != 0) begin
                    logic [7:0] b;
                    b = mq.pop_front();
                    fq.push_back(1'b0);
                    for (int i = 0; i < 8; i++) fq.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
                    fq.push_back(($countones(b) % 2) == 1);
`endif
                    fq.push_back(1'b1);
                end
            end
            if (tx_valid && !full) mq.push_back(data_in);
        end
    end

    task automatic push(input logic [7:0] d);
        int n = 0;
        while (!tx_ready && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 3000) chk("push_timeout", 32'd1, 32'd0);
        tx_valid = 1'b1;
        data_in  = d;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        data_in  = 8'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((tx_busy || fifo_count != 0) && n < 5000) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 5000) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin @(negedge clk); n++; end while (!TX_baud_tick && n < 200);
        if (n >= 200) chk("tick_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_fall();
        int n = 0;
        do begin @(negedge clk); n++; end while (txd && n < 500);
        if (n >= 500) chk("fall_timeout", 32'd1, 32'd0);
    endtask

    task automatic capture_frame(output logic [10:0] w);
        w = '0;
        wait_fall();
        for (int k = 0; k < FRAME_LEN; k++) begin
            if (k != 0 || !TX_baud_tick) wait_tick();
            w[k] = txd;
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [10:0] got;
        logic [10:0] exp;
        int zeros;

        vecs[0] = '{8'hA5, 1'b0};
        vecs[1] = '{8'h07, 1'b1};
        vecs[2] = '{8'hFF, 1'b0};
        vecs[3] = '{8'h00, 1'b0};
        vecs[4] = '{8'h80, 1'b1};
        vecs[5] = '{8'h3C, 1'b0};
        vecs[6] = '{8'h01, 1'b1};
        vecs[7] = '{8'h6E, 1'b1};

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Idle after reset: ticks but no pushes
        mode  = 1;
        zeros = 0;
        repeat (40) begin
            @(negedge clk);
            if (!txd) zeros++;
        end
        @(posedge clk); #1;
        chk("idle_low_cycles", 32'(zeros), 32'd0);
        chk("idle_count", 32'(fifo_count), 32'd0);

        // Directed frames from the vector table
        foreach (vecs[i]) begin
            wait_idle();
            push(vecs[i].data);
            capture_frame(got);
`ifdef UART_TX_PARITY_EN
            exp = {1'b1, vecs[i].par, vecs[i].data, 1'b0};
`else
            exp = {2'b01, vecs[i].data, 1'b0};
`endif
            chk($sformatf("frame_%02h", vecs[i].data), 32'(got), 32'(exp));
        end

        // Five bytes back-to-back into a depth-4 FIFO
        wait_idle();
        for (int b = 8'h11; b <= 8'h15; b++) push(8'(b));
        chk("b2b_count_full", 32'(fifo_count), 32'd4);
        chk("b2b_ready_low", 32'(tx_ready), 32'd0);
        wait_idle();

        // Full FIFO: push and pop in the same cycle, push refused
        mode = 0;
        @(posedge clk); #1;
        for (int b = 0; b < 4; b++) push(8'hC1 + 8'(b));
        chk("full_ready", 32'(tx_ready), 32'd0);
        man_tick = 1'b1;
        tx_valid = 1'b1;
        data_in  = 8'h99;
        @(posedge clk); #1;
        man_tick = 1'b0;
        tx_valid = 1'b0;
        chk("pushpop_count", 32'(fifo_count), 32'd3);
        chk("pushpop_busy", 32'(tx_busy), 32'd1);
        mode = 1;
        wait_idle();

        // Reset during DATA bit 3 of 0xFF with two bytes queued
        mode = 0;
        @(posedge clk); #1;
        push(8'hFF);
        push(8'h12);
        push(8'h34);
        mode = 1;
        wait_fall();
        repeat (4) wait_tick();
        @(posedge clk); #1;
        chk("pre_rst_count", 32'(fifo_count), 32'd2);
        reset_n = 1'b0;
        #1;
        chk("async_rst_txd", 32'(txd), 32'd1);
        chk("async_rst_busy", 32'(tx_busy), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        chk("post_rst_count", 32'(fifo_count), 32'd0);
        zeros = 0;
        repeat (80) begin
            @(negedge clk);
            if (!txd) zeros++;
        end
        @(posedge clk); #1;
        chk("post_rst_no_frame", 32'(zeros), 32'd0);

        // Random traffic against the model, random tick spacing
        mode = 2;
        repeat (800) begin
            tx_valid = ($urandom_range(0, 2) == 0);
            data_in  = 8'($urandom);
            @(posedge clk); #1;
        end
        tx_valid = 1'b0;
        wait_idle();
        repeat (20) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
